// File: rtl/mdio_dance_instructor.sv
// MDIO management master (clause-22 frames).
// Accepts one read/write command at a time, serialises the preamble/header/
// turnaround/data frame on MDC/MDIO, samples read data on MDC rising edges
// and reports completion with a single-cycle response pulse.
module mdio_dance_instructor #(
  parameter int CLK_DIV      = 20,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clkDiscoMaster,
  input  logic        rstDanceFloorN,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic        cmdWrite,
  input  logic [4:0]  cmdPhyAddr,
  input  logic [4:0]  cmdRegAddr,
  input  logic [15:0] cmdWrData,
  output logic        rspValid,
  output logic [15:0] rspRdData,
  output logic        rspNoAck,
  output logic        mdioConductor,
  output logic        mdioDriveOut,
  output logic        mdioDriveEn,
  input  logic        mdioDanceIn
);

  generate
    if (CLK_DIV < 4 || CLK_DIV > 255) begin : g_bad_clk_div
      $error("mdio_dance_instructor: CLK_DIV must be within 4..255");
    end
    if (PREAMBLE_LEN < 1) begin : g_bad_preamble
      $error("mdio_dance_instructor: PREAMBLE_LEN must be at least 1");
    end
  endgenerate

  // Phase counter runs 0..2*CLK_DIV-1 inside a bit and up to 2*CLK_DIV in GAP
  // (510 at most), so 9 bits never wrap.
  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] BIT_LAST  = 9'(2 * CLK_DIV - 1);
  localparam logic [8:0] GAP_LEN   = 9'(2 * CLK_DIV);

  // Bit counter must hold the longest per-state index (preamble or 16 data bits).
  localparam int BMAX = (PREAMBLE_LEN > 16) ? PREAMBLE_LEN : 16;
  localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;
  localparam logic [BW-1:0] PRE_LAST  = BW'(PREAMBLE_LEN - 1);
  localparam logic [BW-1:0] HDR_LAST  = BW'(13);
  localparam logic [BW-1:0] TA_LAST   = BW'(1);
  localparam logic [BW-1:0] DATA_LAST = BW'(15);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, GAP} state_t;

  state_t        state_reg;
  logic [8:0]    phase_reg;
  logic [BW-1:0] bit_reg;
  logic [31:0]   frame_reg;      // start, op, phy, reg, TA, data; MSB goes out first
  logic          write_reg;
  logic [15:0]   rx_reg;
  logic          no_ack_reg;
  logic          cmd_ready_reg;
  logic          rsp_valid_reg;
  logic [15:0]   rsp_rd_data_reg;
  logic          rsp_no_ack_reg;
  logic          mdc_reg;
  logic          drive_out_reg;
  logic          drive_en_reg;
  logic          sync_meta_reg;
  logic          sync_reg;

  // Two-flop synchroniser on the MDIO input; idles high like the bus pull-up.
  always_ff @(posedge clkDiscoMaster or negedge rstDanceFloorN) begin
    if (!rstDanceFloorN) begin
      sync_meta_reg <= 1'b1;
      sync_reg      <= 1'b1;
    end else begin
      sync_meta_reg <= mdioDanceIn;
      sync_reg      <= sync_meta_reg;
    end
  end

  // Frame sequencer: command capture, bit timing, shifting, sampling, response.
  always_ff @(posedge clkDiscoMaster or negedge rstDanceFloorN) begin
    if (!rstDanceFloorN) begin
      state_reg       <= IDLE;
      phase_reg       <= '0;
      bit_reg         <= '0;
      frame_reg       <= '0;
      write_reg       <= 1'b0;
      rx_reg          <= '0;
      no_ack_reg      <= 1'b0;
      cmd_ready_reg   <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rd_data_reg <= '0;
      rsp_no_ack_reg  <= 1'b0;
      mdc_reg         <= 1'b0;
      drive_out_reg   <= 1'b1;
      drive_en_reg    <= 1'b0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          mdc_reg       <= 1'b0;
          drive_en_reg  <= 1'b0;
          drive_out_reg <= 1'b1;
          if (cmd_ready_reg && cmdValid) begin
            // First preamble bit starts right away: MDC low, driving '1'.
            cmd_ready_reg <= 1'b0;
            state_reg     <= PRE;
            phase_reg     <= '0;
            bit_reg       <= '0;
            write_reg     <= cmdWrite;
            frame_reg     <= {2'b01, (cmdWrite ? 2'b01 : 2'b10), cmdPhyAddr,
                              cmdRegAddr, 2'b10, cmdWrData};
            rx_reg        <= '0;
            no_ack_reg    <= 1'b0;
            drive_en_reg  <= 1'b1;
            drive_out_reg <= 1'b1;
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        PRE, HDR, TA, DATA: begin
          phase_reg <= phase_reg + 9'd1;
          if (phase_reg == HALF_LAST) begin
            // MDC rises; capture the synchronised pin for this bit.
            mdc_reg <= 1'b1;
            if (state_reg == TA && bit_reg == TA_LAST) begin
              no_ack_reg <= sync_reg;
            end
            if (state_reg == DATA) begin
              rx_reg <= {rx_reg[14:0], sync_reg};
            end
          end
          if (phase_reg == BIT_LAST) begin
            // Bit boundary: MDC falls and the next bit value is launched.
            phase_reg <= '0;
            mdc_reg   <= 1'b0;
            case (state_reg)
              PRE: begin
                if (bit_reg == PRE_LAST) begin
                  state_reg     <= HDR;
                  bit_reg       <= '0;
                  drive_out_reg <= frame_reg[31];
                  frame_reg     <= {frame_reg[30:0], 1'b0};
                end else begin
                  bit_reg       <= bit_reg + 1'b1;
                  drive_out_reg <= 1'b1;
                end
              end
              HDR: begin
                drive_out_reg <= frame_reg[31];
                frame_reg     <= {frame_reg[30:0], 1'b0};
                if (bit_reg == HDR_LAST) begin
                  // Reads hand the bus to the PHY from the first TA bit on.
                  state_reg    <= TA;
                  bit_reg      <= '0;
                  drive_en_reg <= write_reg;
                end else begin
                  bit_reg <= bit_reg + 1'b1;
                end
              end
              TA: begin
                drive_out_reg <= frame_reg[31];
                frame_reg     <= {frame_reg[30:0], 1'b0};
                if (bit_reg == TA_LAST) begin
                  state_reg <= DATA;
                  bit_reg   <= '0;
                end else begin
                  bit_reg <= bit_reg + 1'b1;
                end
              end
              DATA: begin
                if (bit_reg == DATA_LAST) begin
                  state_reg     <= GAP;
                  bit_reg       <= '0;
                  drive_en_reg  <= 1'b0;
                  drive_out_reg <= 1'b1;
                end else begin
                  bit_reg       <= bit_reg + 1'b1;
                  drive_out_reg <= frame_reg[31];
                  frame_reg     <= {frame_reg[30:0], 1'b0};
                end
              end
              default: ;
            endcase
          end
        end

        GAP: begin
          // Bus released; respond one cycle after the frame, then idle for T.
          mdc_reg       <= 1'b0;
          drive_en_reg  <= 1'b0;
          drive_out_reg <= 1'b1;
          phase_reg     <= phase_reg + 9'd1;
          if (phase_reg == 9'd0) begin
            rsp_valid_reg   <= 1'b1;
            rsp_rd_data_reg <= write_reg ? 16'h0000 : rx_reg;
            rsp_no_ack_reg  <= write_reg ? 1'b0 : no_ack_reg;
          end
          if (phase_reg == GAP_LEN) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            cmd_ready_reg <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign cmdReady      = cmd_ready_reg;
  assign rspValid      = rsp_valid_reg;
  assign rspRdData     = rsp_rd_data_reg;
  assign rspNoAck      = rsp_no_ack_reg;
  assign mdioConductor = mdc_reg;
  assign mdioDriveOut  = drive_out_reg;
  assign mdioDriveEn   = drive_en_reg;

endmodule

// File: tb/tb_mdio_dance_instructor.sv
// Scoreboard bench for mdio_dance_instructor with CLK_DIV=4, PREAMBLE_LEN=32.
// A driver issues commands and queues expected responses; a bus monitor with a
// simple PHY model checks each frame; a response monitor pops and compares.
module tb_mdio_dance_instructor;

  localparam int CD      = 4;
  localparam int PL      = 32;
  localparam int T       = 2 * CD;
  localparam int NBITS   = PL + 32;
  localparam int RSP_LAT = (PL + 32) * T + 1;
  localparam int SPACING = (PL + 33) * T + 2;

  logic        clk;
  logic        rst_n;
  logic        cmdValid;
  logic        cmdReady;
  logic        cmdWrite;
  logic [4:0]  cmdPhyAddr;
  logic [4:0]  cmdRegAddr;
  logic [15:0] cmdWrData;
  logic        rspValid;
  logic [15:0] rspRdData;
  logic        rspNoAck;
  logic        mdc;
  logic        mdio_out;
  logic        mdio_en;
  logic        pin;

  mdio_dance_instructor #(.CLK_DIV(CD), .PREAMBLE_LEN(PL)) dut (
    .clkDiscoMaster(clk),
    .rstDanceFloorN(rst_n),
    .cmdValid(cmdValid),
    .cmdReady(cmdReady),
    .cmdWrite(cmdWrite),
    .cmdPhyAddr(cmdPhyAddr),
    .cmdRegAddr(cmdRegAddr),
    .cmdWrData(cmdWrData),
    .rspValid(rspValid),
    .rspRdData(rspRdData),
    .rspNoAck(rspNoAck),
    .mdioConductor(mdc),
    .mdioDriveOut(mdio_out),
    .mdioDriveEn(mdio_en),
    .mdioDanceIn(pin)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        noack;
    int          acc;
  } rsp_t;
  rsp_t rsp_q[$];

  // current frame context shared with the bus monitor
  bit               frame_active = 0;
  int               frame_bit;
  int               cur_acc;
  bit               cur_wr;
  bit               phy_present;
  bit               phy_ta2;
  logic [15:0]      phy_data;
  logic [NBITS-1:0] exp_bits;
  logic [NBITS-1:0] exp_en;
  logic [NBITS-1:0] got_bits;
  logic [NBITS-1:0] got_en;
  int               late_rises;

  int          last_acc  = 0;
  bit          prev_held = 0;
  logic [15:0] last_rd   = 16'h0000;
  logic        last_na   = 1'b0;

  // Reference frame: bit k is the k-th bit on the wire.
  function automatic void model_frame(input bit wr, input logic [4:0] phy, input logic [4:0] rg,
                                      input logic [15:0] wd,
                                      output logic [NBITS-1:0] bits, output logic [NBITS-1:0] en);
    bit q[$];
    for (int i = 0; i < PL; i++) q.push_back(1'b1);
    q.push_back(1'b0); q.push_back(1'b1);
    if (wr) begin q.push_back(1'b0); q.push_back(1'b1); end
    else    begin q.push_back(1'b1); q.push_back(1'b0); end
    for (int i = 4; i >= 0; i--) q.push_back(phy[i]);
    for (int i = 4; i >= 0; i--) q.push_back(rg[i]);
    if (wr) begin q.push_back(1'b1); q.push_back(1'b0); end
    else    begin q.push_back(1'b0); q.push_back(1'b0); end
    for (int i = 15; i >= 0; i--) q.push_back(wr ? wd[i] : 1'b0);
    for (int k = 0; k < NBITS; k++) begin
      bits[k] = q[k];
      en[k]   = wr ? 1'b1 : (k < PL + 14);
    end
  endfunction

  // Bus monitor + PHY model: acts on every MDC rise of the active frame.
  initial begin
    logic prev_mdc;
    prev_mdc = 1'b0;
    forever begin
      @(negedge clk);
      if (mdc === 1'b1 && prev_mdc === 1'b0 && frame_active) begin
        got_bits[frame_bit] = mdio_out;
        got_en[frame_bit]   = mdio_en;
        if (cyc != cur_acc + frame_bit * T + CD) late_rises++;
        if (!cur_wr && phy_present) begin
          if (frame_bit == PL + 14) pin = phy_ta2;
          else if (frame_bit >= PL + 15 && frame_bit <= PL + 30) pin = phy_data[15 - (frame_bit - (PL + 15))];
          else if (frame_bit == PL + 31) pin = 1'b1;
        end
        frame_bit++;
        if (frame_bit == NBITS) begin
          frame_active = 0;
          chk("frame_bits", got_bits & exp_en, exp_bits & exp_en);
          chk("frame_drive_en", got_en, exp_en);
          chk("mdc_rise_timing", late_rises, 0);
        end
      end
      prev_mdc = mdc;
    end
  end

  // Response monitor: pops one expectation per rspValid pulse.
  initial forever begin
    rsp_t e;
    @(negedge clk);
    if (rspValid === 1'b1) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_rspValid", rspValid, 1'b0);
      end else begin
        e = rsp_q.pop_front();
        chk("rsp_latency", cyc - e.acc, RSP_LAT);
        chk("rsp_rd_data", rspRdData, e.data);
        chk("rsp_no_ack", rspNoAck, e.noack);
        chk("gap_bus_idle", {mdc, mdio_en, mdio_out}, 3'b001);
        $display("rsp: acc=%0d data=%h noack=%0b", e.acc, rspRdData, rspNoAck);
        last_rd = e.data;
        last_na = e.noack;
      end
    end
  end

  task automatic issue(input bit wr, input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] wd,
                       input bit present, input bit ta2, input logic [15:0] pd, input bit keep_valid);
    int   waited;
    int   acc;
    rsp_t e;
    @(negedge clk);
    cmdValid = 1'b1; cmdWrite = wr; cmdPhyAddr = phy; cmdRegAddr = rg; cmdWrData = wd;
    waited = 0;
    while (cmdReady !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (cmdReady !== 1'b1) begin
      chk("accept_timeout", cmdReady, 1'b1);
      cmdValid = 1'b0;
      prev_held = 0;
      return;
    end
    acc = cyc + 1;
    if (prev_held) chk("b2b_spacing", acc - last_acc, SPACING);
    chk("rsp_hold", {rspNoAck, rspRdData}, {last_na, last_rd});
    model_frame(wr, phy, rg, wd, exp_bits, exp_en);
    cur_wr = wr; phy_present = present; phy_ta2 = ta2; phy_data = pd;
    cur_acc = acc; frame_bit = 0; late_rises = 0;
    got_bits = '0; got_en = '0;
    frame_active = 1;
    e.acc = acc;
    if (wr)           begin e.data = 16'h0000; e.noack = 1'b0; end
    else if (present) begin e.data = pd;       e.noack = ta2;  end
    else              begin e.data = 16'hFFFF; e.noack = 1'b1; end
    rsp_q.push_back(e);
    $display("cmd: acc=%0d wr=%0b phy=%h reg=%h wd=%h phy_present=%0b ta2=%0b pd=%h",
             acc, wr, phy, rg, wd, present, ta2, pd);
    last_acc = acc;
    prev_held = keep_valid;
    @(negedge clk);
    // scramble fields mid-frame; they must not affect the captured command
    cmdValid   = keep_valid;
    cmdWrite   = 1'($urandom);
    cmdPhyAddr = 5'($urandom);
    cmdRegAddr = 5'($urandom);
    cmdWrData  = 16'($urandom);
  endtask

  initial begin
    int target;
    int waited;
    rst_n = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0;
    cmdPhyAddr = '0; cmdRegAddr = '0; cmdWrData = '0; pin = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_ctrl", {cmdReady, rspValid, rspNoAck, mdc, mdio_en, mdio_out}, 6'b000001);
    chk("reset_rd_data", rspRdData, 16'h0000);
    rst_n = 1'b1;
    chk("ready_before_edge", cmdReady, 1'b0);
    @(negedge clk);
    chk("ready_after_reset", cmdReady, 1'b1);

    // directed cases
    issue(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, 1'b0, 16'h0000, 1'b0);
    issue(1'b0, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b0, 16'hBEEF, 1'b0);
    issue(1'b0, 5'h1F, 5'h1F, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0);
    // back-to-back with valid held and fields changed mid-frame
    issue(1'b1, 5'h0A, 5'h15, 16'hA5C3, 1'b0, 1'b0, 16'h0000, 1'b1);
    issue(1'b0, 5'h11, 5'h04, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1);
    issue(1'b1, 5'h1E, 5'h0B, 16'h8001, 1'b0, 1'b0, 16'h0000, 1'b0);

    // randomized traffic
    for (int i = 0; i < 8; i++) begin
      issue(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), 16'($urandom),
            1'($urandom));
    end

    // reset in the middle of bit 40 of a write frame
    issue(1'b1, 5'h05, 5'h06, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 1'b0);
    target = cur_acc + 40 * T + 2;
    waited = 0;
    while (cyc < target && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("pre_abort_drive_en", mdio_en, 1'b1);
    #1;
    rst_n = 1'b0;
    frame_active = 0;
    rsp_q.delete();
    prev_held = 0;
    last_rd = 16'h0000;
    last_na = 1'b0;
    #1;
    chk("abort_bus", {mdc, mdio_en, mdio_out}, 3'b001);
    chk("abort_ready", cmdReady, 1'b0);
    $display("abort: reset asserted at cycle %0d", cyc);
    repeat (3) @(negedge clk);
    chk("abort_rsp", {rspValid, rspNoAck, rspRdData}, 18'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_abort", cmdReady, 1'b1);
    repeat (600) @(negedge clk);

    // recovery after abort
    issue(1'b0, 5'h07, 5'h09, 16'h0000, 1'b1, 1'b0, 16'h0F0F, 1'b0);
    issue(1'b1, 5'h00, 5'h1F, 16'h5A5A, 1'b0, 1'b0, 16'h0000, 1'b0);

    waited = 0;
    while ((rsp_q.size() != 0 || frame_active) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_pending", rsp_q.size(), 0);
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
